// File: rtl/pipe_out_tx.sv
// Device-to-host pipe-out path: FIFO between user logic and an okPipeOut endpoint, with okWireOut status.
// Optional word counter in status[31:16] enabled by defining PIPE_OUT_TX_WORDCNT_EN.
module pipe_out_tx #(
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned BLOCK_WORDS    = 256,
  parameter logic [31:0] UNDERFLOW_WORD = 32'hDEAD_BEEF
) (
  input  logic        okClk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [31:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic        ep_read,
  output logic [31:0] ep_datain,
  output logic        block_ready,
  output logic [31:0] status
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [31:0]   ep_datain_q, ep_datain_d;
  logic          block_ready_q, block_ready_d;
  logic          underflow_q, underflow_d;
  logic          push, pop, under_rd;

  // Handshake: a word transfers on any cycle where src_valid and src_ready are both high;
  // src_ready depends only on the registered level, never on ep_read.
  assign src_ready = (level_q != LW'(DEPTH));
  assign push      = src_valid && src_ready;
  assign pop       = ep_read && (level_q != '0);
  assign under_rd  = ep_read && (level_q == '0);

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    ep_datain_d   = ep_datain_q;
    underflow_d   = underflow_q;
    block_ready_d = (level_q >= LW'(BLOCK_WORDS));
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      ep_datain_d = mem[rd_ptr_q];
    end
    if (under_rd) begin
      ep_datain_d = UNDERFLOW_WORD;
      underflow_d = 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // A flush discards contents but leaves the last word on the endpoint.
    if (clr) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      level_d       = '0;
      ep_datain_d   = ep_datain_q;
      underflow_d   = 1'b0;
      block_ready_d = 1'b0;
    end
  end

  always_ff @(posedge okClk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      ep_datain_q   <= '0;
      underflow_q   <= 1'b0;
      block_ready_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      ep_datain_q   <= ep_datain_d;
      underflow_q   <= underflow_d;
      block_ready_q <= block_ready_d;
    end
  end

  always_ff @(posedge okClk) begin
    if (push && rst_n && !clr) mem[wr_ptr_q] <= src_data;
  end

  assign ep_datain   = ep_datain_q;
  assign block_ready = block_ready_q;

`ifdef PIPE_OUT_TX_WORDCNT_EN
  logic [15:0] wcnt_q, wcnt_d;

  always_comb begin
    wcnt_d = wcnt_q;
    if (pop) wcnt_d = wcnt_q + 16'd1;
    if (clr) wcnt_d = '0;
  end

  always_ff @(posedge okClk) begin
    if (!rst_n) wcnt_q <= '0;
    else        wcnt_q <= wcnt_d;
  end

  assign status = {wcnt_q, underflow_q, block_ready_q, 14'(level_q)};
`else
  assign status = {16'h0000, underflow_q, block_ready_q, 14'(level_q)};
`endif
endmodule

// File: tb/tb_pipe_out_tx.sv
// Self-checking bench for pipe_out_tx (DEPTH=16, BLOCK_WORDS=8): vector table, corner sequences, random run vs queue model.
module tb_pipe_out_tx;
  localparam int DEPTH = 16;
  localparam int BLOCK = 8;
  localparam logic [31:0] UNDER = 32'hDEAD_BEEF;

  logic        okClk = 1'b0;
  logic        rst_n, clr, src_valid, src_ready, ep_read, block_ready;
  logic [31:0] src_data, ep_datain, status;

  pipe_out_tx #(.DEPTH(DEPTH), .BLOCK_WORDS(BLOCK), .UNDERFLOW_WORD(UNDER)) dut (
    .okClk(okClk), .rst_n(rst_n), .clr(clr),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .ep_read(ep_read), .ep_datain(ep_datain),
    .block_ready(block_ready), .status(status)
  );

  always #5 okClk = ~okClk;

  // Reference model: plain queue plus flags.
  logic [31:0] m_q[$];
  logic [31:0] m_ep = '0;
  logic        m_uf = 1'b0, m_br = 1'b0;
  logic [15:0] m_wcnt = '0;
  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] exp_status();
    logic [15:0] hi;
`ifdef PIPE_OUT_TX_WORDCNT_EN
    hi = m_wcnt;
`else
    hi = 16'h0000;
`endif
    return {hi, m_uf, m_br, 14'(m_q.size())};
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".ep_datain"}, ep_datain, m_ep);
    check({tag, ".src_ready"}, {31'b0, src_ready}, {31'b0, m_q.size() != DEPTH});
    check({tag, ".block_ready"}, {31'b0, block_ready}, {31'b0, m_br});
    check({tag, ".status"}, status, exp_status());
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
  task automatic step(input logic v, input logic [31:0] d, input logic rd,
                      input logic c, input logic r, input string tag);
    int  old;
    logic rdy;
    src_valid = v; src_data = d; ep_read = rd; clr = c; rst_n = r;
    old = m_q.size();
    rdy = (old != DEPTH);
    @(posedge okClk);
    if (!r) begin
      m_q.delete(); m_ep = '0; m_uf = 0; m_br = 0; m_wcnt = '0;
    end else if (c) begin
      m_q.delete(); m_uf = 0; m_br = 0; m_wcnt = '0;
    end else begin
      m_br = (old >= BLOCK);
      if (rd) begin
        if (old > 0) begin
          m_ep = m_q.pop_front();
          m_wcnt++;
        end else begin
          m_ep = UNDER;
          m_uf = 1'b1;
        end
      end
      if (v && rdy) m_q.push_back(d);
    end
    #1;
    check_all(tag);
  endtask

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        rd;
    logic        c;
    logic [31:0] exp_ep;
    int          exp_lvl;
  } vec_t;

  vec_t tbl[10];

  initial begin
    rst_n = 0; clr = 0; src_valid = 0; src_data = '0; ep_read = 0;
    tbl[0] = '{1, 32'hA0A0_0000, 0, 0, 32'h0,        1};
    tbl[1] = '{1, 32'hA1A1_0001, 0, 0, 32'h0,        2};
    tbl[2] = '{1, 32'hA2A2_0002, 0, 0, 32'h0,        3};
    tbl[3] = '{0, 32'h0,         1, 0, 32'hA0A0_0000, 2};
    tbl[4] = '{0, 32'h0,         1, 0, 32'hA1A1_0001, 1};
    tbl[5] = '{0, 32'h0,         1, 0, 32'hA2A2_0002, 0};
    tbl[6] = '{0, 32'h0,         1, 0, UNDER,         0};
    tbl[7] = '{1, 32'hB0B0_0000, 1, 0, UNDER,         1};
    tbl[8] = '{0, 32'h0,         1, 0, 32'hB0B0_0000, 0};
    tbl[9] = '{0, 32'h0,         0, 1, 32'hB0B0_0000, 0};

    // Reset state, including fixed constants independent of the model.
    step(0, 0, 0, 0, 0, "rst");
    step(0, 0, 0, 0, 0, "rst");
    check("rst.status_zero", status, 32'h0);
    check("rst.ep_zero", ep_datain, 32'h0);

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].rd, tbl[i].c, 1, "tbl");
      check($sformatf("tbl%0d.ep", i), ep_datain, tbl[i].exp_ep);
      check($sformatf("tbl%0d.lvl", i), {18'b0, status[13:0]}, 32'(tbl[i].exp_lvl));
      if (i == 6) check("tbl.uf_set", {31'b0, status[15]}, 32'd1);
    end
    check("clr.uf_cleared", {31'b0, status[15]}, 32'd0);

    // Fill past capacity with src_valid held.
    for (int i = 0; i < 20; i++) step(1, 32'hC000_0000 + i, 0, 0, 1, "fill");
    check("fill.level16", {18'b0, status[13:0]}, 32'd16);
    check("fill.not_ready", {31'b0, src_ready}, 32'd0);
    step(1, 32'hC000_0063, 1, 0, 1, "fill_pop");
    check("fill_pop.ep", ep_datain, 32'hC000_0000);
    check("fill_pop.ready", {31'b0, src_ready}, 32'd1);
    step(1, 32'hC000_0064, 0, 0, 1, "fill_17th");
    check("fill_17th.level16", {18'b0, status[13:0]}, 32'd16);

    // Block threshold: block_ready trails the level by one cycle.
    step(0, 0, 0, 1, 1, "clr");
    for (int i = 0; i < BLOCK; i++) step(1, 32'hB100_0000 + i, 0, 0, 1, "blk");
    check("blk.not_yet", {31'b0, block_ready}, 32'd0);
    step(0, 0, 0, 0, 1, "blk_idle");
    check("blk.ready", {31'b0, block_ready}, 32'd1);
    check("blk.status14", {31'b0, status[14]}, 32'd1);
    step(0, 0, 1, 0, 1, "blk_rd");
    step(0, 0, 0, 0, 1, "blk_idle2");
    check("blk.dropped", {31'b0, block_ready}, 32'd0);

    // Level 5, simultaneous push and pop, then flush.
    step(0, 0, 0, 1, 1, "clr");
    for (int i = 0; i < 5; i++) step(1, 32'h5500_0000 + i, 0, 0, 1, "l5");
    step(1, 32'h5500_00FF, 1, 0, 1, "l5_pp");
    check("l5_pp.level", {18'b0, status[13:0]}, 32'd5);
    check("l5_pp.ep", ep_datain, 32'h5500_0000);
    step(0, 0, 0, 1, 1, "l5_clr");
    check("l5_clr.ep_held", ep_datain, 32'h5500_0000);
    check("l5_clr.status", status, 32'h0);

    // Randomized traffic including occasional clr and reset.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 1),
           $urandom_range(0, 40) == 0, $urandom_range(0, 80) != 0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
